// File: rtl/sync_fifo_flagged_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_flagged_pkg : read-mode constants and parameter legality check |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sync_fifo_flagged_pkg;

  localparam int MODE_NORMAL    = 0;
  localparam int MODE_SHOWAHEAD = 1;

  // DEPTH must be a power of two matching PTR; thresholds must lie in range.
  function automatic bit params_legal(input int depth, input int ptr,
                                      input int af, input int ae, input int mode);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) && ((1 << ptr) == depth) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1) &&
           ((mode == MODE_NORMAL) || (mode == MODE_SHOWAHEAD));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flagged_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_flagged_if : producer/consumer bus of the flagged FIFO         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sync_fifo_flagged_if #(
  parameter int WIDTH = 8,
  parameter int PTR   = 4
);
  logic             wren;
  logic [WIDTH-1:0] datain;
  logic             rden;
  logic [WIDTH-1:0] dataout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [PTR:0]     usedw;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wren, datain, rden, clr_err,
    input  dataout, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  wren, datain, rden, clr_err,
    output dataout, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flagged_fifo_mem_2p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_mem_2p : register array, synchronous write / asynchronous read      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR   = 4
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [PTR-1:0]   waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [PTR-1:0]   raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flagged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_flagged : single-clock FIFO with threshold and sticky flags    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo_flagged
  import sync_fifo_flagged_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR       = 4,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = 14,
  parameter int AE_LEVEL  = 2
) (
  input wire logic           clk,
  input wire logic           reset,
  sync_fifo_flagged_if.slave bus
);

  localparam logic [PTR:0] c_DEPTH = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] c_AF    = (PTR+1)'(AF_LEVEL);
  localparam logic [PTR:0] c_AE    = (PTR+1)'(AE_LEVEL);
  localparam logic [PTR:0] c_ONE   = (PTR+1)'(1);

  generate
    if (!params_legal(DEPTH, PTR, AF_LEVEL, AE_LEVEL, SHOWAHEAD)) begin : g_param_check
      $error("sync_fifo_flagged: illegal parameter combination");
    end
  endgenerate

  logic [PTR:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     usedw_q,  usedw_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             ovf_q,    ovf_d;
  logic             udf_q,    udf_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             full_w, empty_w, wr_acc, rd_acc;

  assign full_w  = (usedw_q == c_DEPTH);
  assign empty_w = (usedw_q == '0);
  assign wr_acc  = bus.wren & ~full_w;
  assign rd_acc  = bus.rden & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + c_ONE;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + c_ONE;
      dout_d   = mem_rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + c_ONE;
      2'b01:   usedw_d = usedw_q - c_ONE;
      default: usedw_d = usedw_q;
    endcase
    // A fresh error event outranks a clear in the same cycle.
    ovf_d = (bus.wren & full_w)  | (ovf_q & ~bus.clr_err);
    udf_d = (bus.rden & empty_w) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~reset),
    .waddr (wr_ptr_q[PTR-1:0]),
    .wdata (bus.datain),
    .raddr (rd_ptr_q[PTR-1:0]),
    .rdata (mem_rdata)
  );

  // dout_q doubles as the normal-mode output register and the show-ahead
  // holding register: both capture the head word on every accepted read.
  generate
    if (SHOWAHEAD == MODE_SHOWAHEAD) begin : g_showahead
      assign bus.dataout = empty_w ? dout_q : mem_rdata;
    end else begin : g_normal
      assign bus.dataout = dout_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (usedw_q >= c_AF);
  assign bus.almost_empty = (usedw_q <= c_AE);
  assign bus.usedw        = usedw_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flagged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_fifo_flagged : directed checks of normal and show-ahead FIFOs    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_flagged;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_flagged_if #(.WIDTH(8), .PTR(4)) if_n ();
  sync_fifo_flagged_if #(.WIDTH(8), .PTR(4)) if_s ();

  sync_fifo_flagged #(.SHOWAHEAD(0)) u_norm (.clk(clk), .reset(reset), .bus(if_n));
  sync_fifo_flagged #(.SHOWAHEAD(1)) u_sa   (.clk(clk), .reset(reset), .bus(if_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {if_n.wren, if_n.rden, if_n.clr_err, if_n.datain} = '0;
    {if_s.wren, if_s.rden, if_s.clr_err, if_s.datain} = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_usedw", 32'(if_n.usedw), 0);
    chk("rst_empty", 32'(if_n.empty), 1);
    chk("rst_full",  32'(if_n.full), 0);
    chk("rst_ae",    32'(if_n.almost_empty), 1);
    chk("rst_af",    32'(if_n.almost_full), 0);
    chk("rst_dout",  32'(if_n.dataout), 0);
    chk("rst_ovf",   32'(if_n.overflow), 0);
    chk("rst_udf",   32'(if_n.underflow), 0);
    chk("rst_sa_dout", 32'(if_s.dataout), 0);

    // Fill to full, watching threshold flags
    for (int i = 1; i <= 16; i++) begin
      if_n.wren = 1'b1;
      if_n.datain = 8'(i);
      tick();
      chk("fill_usedw", 32'(if_n.usedw), 32'(i));
      chk("fill_af",    32'(if_n.almost_full), (i >= 14) ? 1 : 0);
      chk("fill_ae",    32'(if_n.almost_empty), (i <= 2) ? 1 : 0);
      chk("fill_full",  32'(if_n.full), (i == 16) ? 1 : 0);
      chk("fill_empty", 32'(if_n.empty), 0);
    end

    // Write into full FIFO
    if_n.datain = 8'hAA;
    tick();
    if_n.wren = 1'b0;
    chk("ovf_set",   32'(if_n.overflow), 1);
    chk("ovf_usedw", 32'(if_n.usedw), 16);
    tick();
    chk("ovf_sticky", 32'(if_n.overflow), 1);
    if_n.clr_err = 1'b1;
    tick();
    if_n.clr_err = 1'b0;
    chk("ovf_clr", 32'(if_n.overflow), 0);

    // Drain: 0x01..0x10 in order, 0xAA never appears
    for (int i = 1; i <= 16; i++) begin
      if_n.rden = 1'b1;
      tick();
      chk("drain_dout", 32'(if_n.dataout), 32'(i));
    end
    if_n.rden = 1'b0;
    chk("drain_empty", 32'(if_n.empty), 1);
    chk("drain_usedw", 32'(if_n.usedw), 0);

    // Normal mode latency and underflow
    if_n.wren = 1'b1;
    if_n.datain = 8'h11; tick();
    if_n.datain = 8'h22; tick();
    if_n.datain = 8'h33; tick();
    if_n.wren = 1'b0;
    chk("n3_dout_idle", 32'(if_n.dataout), 32'h10);
    if_n.rden = 1'b1;
    tick(); chk("n3_rd1", 32'(if_n.dataout), 32'h11);
    tick(); chk("n3_rd2", 32'(if_n.dataout), 32'h22);
    tick(); chk("n3_rd3", 32'(if_n.dataout), 32'h33);
    chk("n3_empty", 32'(if_n.empty), 1);
    chk("n3_udf0",  32'(if_n.underflow), 0);
    tick();
    chk("n3_udf1", 32'(if_n.underflow), 1);
    chk("n3_hold", 32'(if_n.dataout), 32'h33);
    chk("n3_usedw", 32'(if_n.usedw), 0);
    // Set and clear in the same cycle: set wins
    if_n.clr_err = 1'b1;
    tick();
    chk("udf_set_wins", 32'(if_n.underflow), 1);
    if_n.rden = 1'b0;
    tick();
    if_n.clr_err = 1'b0;
    chk("udf_clr", 32'(if_n.underflow), 0);

    // Simultaneous write+read on empty: write accepted, read rejected
    if_n.wren = 1'b1; if_n.rden = 1'b1; if_n.datain = 8'h44;
    tick();
    if_n.wren = 1'b0; if_n.rden = 1'b0;
    chk("we_re_empty_usedw", 32'(if_n.usedw), 1);
    chk("we_re_empty_udf",   32'(if_n.underflow), 1);
    chk("we_re_empty_dout",  32'(if_n.dataout), 32'h33);
    if_n.rden = 1'b1; if_n.clr_err = 1'b1;
    tick();
    if_n.rden = 1'b0; if_n.clr_err = 1'b0;
    chk("we_re_empty_pop", 32'(if_n.dataout), 32'h44);

    // Show-ahead
    if_s.wren = 1'b1; if_s.datain = 8'h5A;
    tick();
    if_s.wren = 1'b0;
    chk("sa_dout", 32'(if_s.dataout), 32'h5A);
    chk("sa_empty", 32'(if_s.empty), 0);
    tick();
    chk("sa_stable", 32'(if_s.dataout), 32'h5A);
    if_s.rden = 1'b1;
    tick();
    if_s.rden = 1'b0;
    chk("sa_pop_empty", 32'(if_s.empty), 1);
    chk("sa_pop_hold",  32'(if_s.dataout), 32'h5A);
    if_s.wren = 1'b1;
    if_s.datain = 8'h61; tick();
    if_s.datain = 8'h62; tick();
    if_s.wren = 1'b0;
    chk("sa_head", 32'(if_s.dataout), 32'h61);
    if_s.rden = 1'b1;
    tick(); chk("sa_next", 32'(if_s.dataout), 32'h62);
    tick(); chk("sa_hold2", 32'(if_s.dataout), 32'h62);
    chk("sa_empty2", 32'(if_s.empty), 1);
    tick();
    if_s.rden = 1'b0;
    chk("sa_udf", 32'(if_s.underflow), 1);
    chk("sa_hold3", 32'(if_s.dataout), 32'h62);

    // Streaming at usedw=8 across several pointer wraps
    if_n.wren = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if_n.datain = 8'(8'h80 + k);
      tick();
    end
    chk("st_usedw0", 32'(if_n.usedw), 8);
    if_n.rden = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if_n.datain = 8'(8'h88 + k);
      tick();
      chk("st_usedw", 32'(if_n.usedw), 8);
      chk("st_dout",  32'(if_n.dataout), 32'(8'h80 + k));
    end
    if_n.rden = 1'b0;
    if_n.datain = 8'hB0;
    tick();
    if_n.wren = 1'b0;
    chk("pre_rst_usedw", 32'(if_n.usedw), 9);

    // Reset mid-operation with wren/rden active
    reset = 1'b1; if_n.wren = 1'b1; if_n.rden = 1'b1; if_n.datain = 8'hEE;
    tick();
    reset = 1'b0; if_n.wren = 1'b0; if_n.rden = 1'b0;
    chk("mrst_usedw", 32'(if_n.usedw), 0);
    chk("mrst_empty", 32'(if_n.empty), 1);
    chk("mrst_ae",    32'(if_n.almost_empty), 1);
    chk("mrst_af",    32'(if_n.almost_full), 0);
    chk("mrst_full",  32'(if_n.full), 0);
    chk("mrst_ovf",   32'(if_n.overflow), 0);
    chk("mrst_udf",   32'(if_n.underflow), 0);
    chk("mrst_dout",  32'(if_n.dataout), 0);
    chk("mrst_sa_udf", 32'(if_s.underflow), 0);
    if_n.wren = 1'b1; if_n.datain = 8'h3C;
    tick();
    if_n.wren = 1'b0; if_n.rden = 1'b1;
    tick();
    if_n.rden = 1'b0;
    chk("mrst_new", 32'(if_n.dataout), 32'h3C);
    chk("mrst_new_empty", 32'(if_n.empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Parametrised single-clock FIFO, next generation of the dual-clock FIFO used across the MAC datapath, for paths where producer and consumer share one clock.
Adds programmable almost-full/almost-empty thresholds, selectable normal or show-ahead read mode, and sticky overflow/underflow error flags.
Sits between MAC receive/transmit stages and the host-side buffering logic.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; must be a power of two, at least 2
PTR, 4, log2(DEPTH); pointers and usedw are PTR+1 bits
SHOWAHEAD, 0, 0 = normal read mode (registered dataout), 1 = show-ahead / first-word-fall-through mode
AF_LEVEL, 14, almost_full asserts when usedw >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when usedw <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock for all logic
reset  input  1  synchronous, active-high reset
wren  input  1  write request
datain  input  WIDTH  write data
rden  input  1  read request; in show-ahead mode this is a pop/acknowledge
dataout  output  WIDTH  read data
full  output  1  usedw == DEPTH
empty  output  1  usedw == 0
almost_full  output  1  usedw >= AF_LEVEL
almost_empty  output  1  usedw <= AE_LEVEL
usedw  output  PTR+1  number of stored entries, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clr_err  input  1  clears overflow and underflow

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - wr_ptr, rd_ptr and usedw go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - dataout=0, overflow=0, underflow=0.
  - Memory contents are not reset.
- A reset asserted mid-operation discards all contents at the next edge. Any wren/rden in that cycle is ignored.
- Accept rules, evaluated on registered state at the edge:
  - wr_acc = wren & !full.
  - rd_acc = rden & !empty.
- Pointers:
  - PTR+1 bits wide; they increment by 1 on accept and wrap naturally modulo 2^(PTR+1).
  - Memory is addressed by the low PTR bits.
- usedw is a registered counter:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither accept.
  - It must always equal wr_ptr - rd_ptr (mod 2^(PTR+1)).
- All status flags are decoded combinationally from the registered usedw. Each flag updates in the cycle after the accepting edge.
- Simultaneous wren and rden:
  - When full: the read is accepted, the write is rejected, and overflow is set.
  - When empty: the write is accepted, the read is rejected, and underflow is set.
  - Otherwise both are accepted and usedw is unchanged.
- Normal mode (SHOWAHEAD=0):
  - On rd_acc, dataout <= mem[rd_ptr] at that edge (1-cycle read latency).
  - Otherwise dataout holds its value.
- Show-ahead mode (SHOWAHEAD=1):
  - dataout = mem[rd_ptr] combinationally whenever !empty.
  - rd_acc advances to the next entry.
  - A word written at edge N is visible on dataout after edge N, in the same cycle empty deasserts.
  - When empty, dataout holds the last popped word. This requires a holding register, loaded on rd_acc.
- Sticky error flags:
  - overflow is set on wren & full; underflow is set on rden & empty.
  - Both are cleared by clr_err.
  - If a set event and clr_err occur in the same cycle, set wins.
  - A rejected access never alters pointers, memory or dataout.
- Wrap-around: no special-casing at entry DEPTH-1; full and empty are distinguished solely by usedw (equivalently, the pointer MSB).

Decomposition:
- Shared header/package: DEPTH/PTR legality checks and read-mode constants (MODE_NORMAL=0, MODE_SHOWAHEAD=1).
- One natural sub-module, fifo_mem_2p:
  - WIDTH x DEPTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
- Control logic (pointers, counter, flags, read mode) lives in sync_fifo_flagged.

Test Plan:
1. Reset, then write 16 words 0x01..0x10 with no reads (defaults) -> usedw counts 1..16; almost_full rises when usedw=14; full=1 at usedw=16; empty=0 after the first write.
2. From full, wren=1 with datain=0xAA for 1 cycle -> overflow=1, usedw stays 16, 0xAA is never read. clr_err pulse -> overflow=0.
3. SHOWAHEAD=0: fill 3 words 0x11,0x22,0x33, then rden for 3 cycles -> dataout=0x11,0x22,0x33 one cycle after each accept; empty=1 after the third; a 4th rden sets underflow and dataout holds 0x33.
4. SHOWAHEAD=1: write 0x5A into an empty FIFO -> the next cycle shows dataout=0x5A and empty=0 with no rden. Pop -> empty=1, dataout holds 0x5A.
5. Continuous simultaneous wren/rden for 40 cycles at usedw=8, incrementing data -> usedw constant at 8, pointers wrap at least twice, output sequence in order with no loss.
6. Assert reset at usedw=9 together with wren and rden -> next cycle usedw=0, empty=1, almost_empty=1, flags clear, and a subsequent write/read returns only the new data.
